// File: rtl/audio_uart_store.sv
// ============================================================================
// Module   : audio_uart_store
// Brief    : UART (LSB first) audio receiver that pairs bytes into 16-bit
//            samples and stores them in a two-bank ping-pong buffer swapped
//            by a frame pulse. Define AUD_PARITY_EN for 8E1 framing (8N1 otherwise).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module audio_uart_store #(
  parameter int BAUD_DIV = 434,
  parameter int DEPTH    = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rst,
  input  logic        Rx,
  input  logic [8:0]  rdaddress,
  output logic [15:0] q,
  output logic [13:0] bytes_written,
  output logic        overflow,
  output logic        rx_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [11:0] C_HALF_M1 = 12'(BAUD_DIV / 2 - 1);
  localparam logic [11:0] C_FULL_M1 = 12'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef AUD_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_baud_cnt, w_baud_cnt_nxt;
  logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        w_accept, w_err;
`ifdef AUD_PARITY_EN
  logic        r_par_bad, w_par_bad_nxt;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_accept       = 1'b0;
    w_err          = 1'b0;
`ifdef AUD_PARITY_EN
    w_par_bad_nxt  = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        if (!Rx) begin
          w_state_nxt    = S_START;
          w_baud_cnt_nxt = 12'd0;
        end
      end
      S_START: begin
        if (r_baud_cnt == C_HALF_M1) begin
          w_baud_cnt_nxt = 12'd0;
          w_bit_cnt_nxt  = 3'd0;
          w_state_nxt    = Rx ? S_IDLE : S_DATA;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 12'd1;
        end
      end
      S_DATA: begin
        if (r_baud_cnt == C_FULL_M1) begin
          w_baud_cnt_nxt = 12'd0;
          w_shift_nxt    = {Rx, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
`ifdef AUD_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 12'd1;
        end
      end
`ifdef AUD_PARITY_EN
      S_PARITY: begin
        if (r_baud_cnt == C_FULL_M1) begin
          w_baud_cnt_nxt = 12'd0;
          w_par_bad_nxt  = (^r_shift) ^ Rx;
          w_err          = w_par_bad_nxt;
          w_state_nxt    = S_STOP;
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 12'd1;
        end
      end
`endif
      S_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed
        if (r_baud_cnt == C_FULL_M1) begin
          w_baud_cnt_nxt = 12'd0;
          w_state_nxt    = S_IDLE;
          if (Rx) begin
`ifdef AUD_PARITY_EN
            w_accept = !r_par_bad;
`else
            w_accept = 1'b1;
`endif
          end else begin
            w_err = 1'b1;
          end
        end else begin
          w_baud_cnt_nxt = r_baud_cnt + 12'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= 12'd0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      rx_err     <= 1'b0;
`ifdef AUD_PARITY_EN
      r_par_bad  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      rx_err     <= w_err;
`ifdef AUD_PARITY_EN
      r_par_bad  <= w_par_bad_nxt;
`endif
    end
  end

  logic          r_wr_bank;
  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count [2];
  logic          r_lo_pending;
  logic [7:0]    r_lo_byte;
  logic          w_room, w_store;
  logic [15:0]   mem [0:2*DEPTH-1];

  assign w_room  = (r_wr_ptr < C_DEPTH);
  assign w_store = w_accept && r_lo_pending && w_room;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_bank     <= 1'b0;
      r_wr_ptr      <= '0;
      r_count[0]    <= '0;
      r_count[1]    <= '0;
      r_lo_pending  <= 1'b0;
      r_lo_byte     <= 8'd0;
      bytes_written <= 14'd0;
      overflow      <= 1'b0;
    end else if (rst) begin
      // A sample completing on the pulse still belongs to the closing frame
      r_count[r_wr_bank] <= w_store ? r_wr_ptr + CW'(1) : r_wr_ptr;
      r_wr_bank     <= ~r_wr_bank;
      r_wr_ptr      <= '0;
      r_lo_pending  <= 1'b0;
      bytes_written <= 14'd0;
      overflow      <= 1'b0;
    end else if (w_accept) begin
      if (bytes_written != 14'h3FFF) begin
        bytes_written <= bytes_written + 14'd1;
      end
      if (!r_lo_pending) begin
        r_lo_byte    <= r_shift;
        r_lo_pending <= 1'b1;
      end else begin
        r_lo_pending <= 1'b0;
        if (w_room) begin
          r_wr_ptr <= r_wr_ptr + CW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_store) begin
      mem[{r_wr_bank, r_wr_ptr[AW-1:0]}] <= {r_shift, r_lo_byte};
    end
  end

  logic          w_rd_bank;
  logic [AW-1:0] w_rd_idx;

  assign w_rd_bank = ~r_wr_bank;
  assign w_rd_idx  = rdaddress[AW-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= 16'h0000;
    end else if ({1'b0, w_rd_idx} < r_count[w_rd_bank]) begin
      q <= mem[{w_rd_bank, w_rd_idx}];
    end else begin
      q <= 16'h0000;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_audio_uart_store.sv
// ============================================================================
// Module   : tb_audio_uart_store
// Brief    : Directed bench for audio_uart_store (BAUD_DIV=16, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_audio_uart_store;

  localparam int BAUD  = 16;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        rst;
  logic        Rx;
  logic [8:0]  rdaddress;
  logic [15:0] q;
  logic [13:0] bytes_written;
  logic        overflow;
  logic        rx_err;

  int n_checks     = 0;
  int n_errors     = 0;
  int n_err_pulses = 0;
  int e0;

  audio_uart_store #(.BAUD_DIV(BAUD), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .rst           (rst),
    .Rx            (Rx),
    .rdaddress     (rdaddress),
    .q             (q),
    .bytes_written (bytes_written),
    .overflow      (overflow),
    .rx_err        (rx_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rx_err === 1'b1) n_err_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    repeat (BAUD) @(negedge clock);
  endtask

  // Stop-bit sample lands on the 9th rising edge of the stop bit; pulse_at_stop
  // raises the frame pulse on exactly that edge.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit = 1'b1,
                           input logic par_flip = 1'b0, input logic pulse_at_stop = 1'b0,
                           input int idle = 0);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef AUD_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    Rx = stop_bit;
    for (int j = 0; j < BAUD; j++) begin
      if (pulse_at_stop && j == 8) rst = 1'b1;
      if (pulse_at_stop && j == 9) rst = 1'b0;
      @(negedge clock);
    end
    Rx = 1'b1;
    repeat (idle) @(negedge clock);
  endtask

  task automatic frame_pulse();
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [8:0] a, input logic [15:0] exp);
    rdaddress = a;
    @(negedge clock);
    check(tag, {16'h0, q}, {16'h0, exp});
  endtask

  initial begin
    Rx = 1'b1; rst = 1'b0; reset = 1'b1; rdaddress = 9'd0;
    repeat (3) @(negedge clock);
    check("reset_q", {16'h0, q}, 32'h0);
    check("reset_bw", {18'h0, bytes_written}, 32'h0);
    check("reset_ovf", {31'h0, overflow}, 32'h0);
    check("reset_err", {31'h0, rx_err}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    read_check("rd_before_pulse", 9'd0, 16'h0000);

    // basic pair
    send_byte(8'h34);
    send_byte(8'h12);
    check("bw_pair", {18'h0, bytes_written}, 32'd2);
    frame_pulse();
    check("bw_after_pulse", {18'h0, bytes_written}, 32'd0);
    read_check("rd0_1234", 9'd0, 16'h1234);
    read_check("rd1_empty", 9'd1, 16'h0000);
    read_check("rd_upper_ignored", 9'h100, 16'h1234);

    // overflow: 19 samples into a 16-deep bank
    for (int s = 0; s < 19; s++) begin
      send_byte(8'(s * 3 + 1));
      send_byte(8'(8'hC0 + s));
      if (s == 15) check("ovf_at_full", {31'h0, overflow}, 32'h0);
    end
    check("ovf_set", {31'h0, overflow}, 32'h1);
    check("bw_38", {18'h0, bytes_written}, 32'd38);
    frame_pulse();
    check("ovf_cleared", {31'h0, overflow}, 32'h0);
    check("bw_cleared", {18'h0, bytes_written}, 32'd0);
    read_check("ovf_rd0", 9'd0, 16'hC001);
    read_check("ovf_rd7", 9'd7, 16'hC716);
    read_check("ovf_rd15", 9'd15, 16'hCF2E);

    // sample completes on the frame pulse
    send_byte(8'hCD);
    send_byte(8'hAB);
    send_byte(8'h78);
    send_byte(8'h56, 1'b1, 1'b0, 1'b1, 0);
    check("coinc_bw", {18'h0, bytes_written}, 32'd0);
    read_check("coinc_rd0", 9'd0, 16'hABCD);
    read_check("coinc_rd1", 9'd1, 16'h5678);
    read_check("coinc_rd2", 9'd2, 16'h0000);

    // framing error
    e0 = n_err_pulses;
    send_byte(8'h99, 1'b0, 1'b0, 1'b0, 48);
    check("stop_err_pulse", n_err_pulses - e0, 32'd1);
    check("stop_err_bw", {18'h0, bytes_written}, 32'd0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    check("after_err_bw", {18'h0, bytes_written}, 32'd2);
    frame_pulse();
    read_check("after_err_rd0", 9'd0, 16'hBEEF);
    read_check("after_err_rd1", 9'd1, 16'h0000);

    // glitch on Rx
    send_byte(8'h55);
    e0 = n_err_pulses;
    Rx = 1'b0;
    repeat (4) @(negedge clock);
    Rx = 1'b1;
    repeat (40) @(negedge clock);
    check("glitch_bw", {18'h0, bytes_written}, 32'd1);
    check("glitch_err", n_err_pulses - e0, 32'd0);

    // reset mid-byte
    read_check("pre_reset_q", 9'd0, 16'hBEEF);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    #1;
    check("mid_reset_q", {16'h0, q}, 32'h0);
    check("mid_reset_bw", {18'h0, bytes_written}, 32'h0);
    check("mid_reset_ovf", {31'h0, overflow}, 32'h0);
    check("mid_reset_err", {31'h0, rx_err}, 32'h0);
    Rx = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    send_byte(8'h21);
    send_byte(8'h43);
    check("post_reset_bw", {18'h0, bytes_written}, 32'd2);
    frame_pulse();
    read_check("post_reset_rd0", 9'd0, 16'h4321);

`ifdef AUD_PARITY_EN
    e0 = n_err_pulses;
    send_byte(8'h01, 1'b1, 1'b1, 1'b0, 40);
    check("par_bad_pulse", n_err_pulses - e0, 32'd1);
    check("par_bad_bw", {18'h0, bytes_written}, 32'd0);
    send_byte(8'h01);
    check("par_ok_bw", {18'h0, bytes_written}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/audio_uart_store.md
Name: audio_uart_store

Overview:
- Upstream audio capture stage for the CC/LPC frame assembler.
- Receives one synchronized serial audio stream (UART, LSB first) and assembles byte pairs into 16-bit samples.
- Stores samples in a ping-pong buffer of two banks x DEPTH words.
- Each frame pulse swaps banks, so the assembler reads a stable, complete previous frame while the next frame is written.

Parameters:
- BAUD_DIV, 434, clocks per bit period (50 MHz / 115200); legal range 8..4095.
- DEPTH, 512, samples per bank; power of two, at most 512.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rst  in  1  frame pulse, one clock wide, synchronous; swaps banks
- Rx  in  1  serial audio input, already synchronized to clock, idle high
- rdaddress  in  9  sample read address within the read bank
- q  out  16  sample data, registered
- bytes_written  out  14  bytes accepted in the current frame, saturating
- overflow  out  1  sticky flag: a sample was dropped in the current frame (bank full)
- rx_err  out  1  one-clock pulse on a framing or parity error

Behaviour:
- Reset: asynchronous, active-high; clock is clock.
  - Values on reset: q=0, bytes_written=0, overflow=0, rx_err=0, wr_bank=0, wr_ptr=0, low-byte-pending=0, both bank sample counts=0.
  - Reset mid-byte abandons the byte. RAM contents are not cleared.
- Receiver FSM: IDLE, START, DATA, (PARITY), STOP.
  - IDLE -> START on Rx=0.
  - START: wait BAUD_DIV/2 clocks, then re-sample Rx.
    - Rx=1: false start, return to IDLE with no error.
    - Rx=0: go to DATA.
  - DATA: sample 8 bits at BAUD_DIV intervals, LSB first.
  - STOP: sample once. Rx=1 accepts the byte. Rx=0 discards the byte and pulses rx_err.
  - STOP returns to IDLE immediately after sampling and does not wait a full stop bit.
- Byte accept:
  - bytes_written += 1, saturating at 16383.
  - First byte of a pair is latched as the low byte.
  - Second byte forms sample {hi, lo}.
  - If wr_ptr < DEPTH, the sample is written at wr_ptr of wr_bank and wr_ptr increments.
  - Otherwise the sample is dropped and overflow is set.
- Frame pulse (rst=1):
  - Read bank = old wr_bank; its sample count is latched from wr_ptr.
  - wr_bank toggles.
  - wr_ptr, bytes_written, overflow and low-byte-pending clear; a pending low byte is discarded.
  - The receiver FSM is not disturbed, so a byte in flight completes into the new frame.
- Simultaneous frame pulse and sample completion:
  - The sample is written to the old bank (counted only if wr_ptr < DEPTH), then the swap happens.
  - The latched count includes that sample.
  - The accepted byte is not counted in the new bytes_written.
- Read port:
  - q is valid 1 clock after rdaddress.
  - rdaddress >= the read bank's latched count returns 16'h0000. This also covers the state before the first frame pulse.
  - rdaddress bits above log2(DEPTH) are ignored.
- Write and read never target the same bank, so there is no read-during-write hazard.
- rx_err is a single clock pulse and does not affect the byte pairing.

Optional Feature:
- Macro AUD_PARITY_EN.
- Defined: frames are 8E1. A PARITY state samples the 9th bit after the data bits. Even parity mismatch discards the byte, pulses rx_err, and STOP is still sampled.
- Undefined: frames are 8N1 with no PARITY state and no parity logic.

Test Plan:
- BAUD_DIV=16; send bytes 0x34, 0x12, then frame pulse -> bytes_written=2 before the pulse and 0 after. rdaddress=0 gives q=16'h1234 one clock later; rdaddress=1 gives q=0.
- Send 1030 bytes (515 samples) in one frame, then pulse -> overflow=1 before the pulse, bytes_written=1030. Samples 0..511 are stored, 512..514 are dropped, and overflow=0 after the pulse.
- Sample completion coincides with the frame pulse -> the sample lands in the old bank at its index. The latched count includes it, and the new bytes_written is 0.
- Byte with stop bit forced 0 -> rx_err pulses exactly 1 clock. bytes_written is unchanged and the next valid byte pairs as a low byte.
- 4-clock low glitch on Rx (BAUD_DIV=16) -> no byte accepted, no rx_err. Reset asserted mid-byte -> all outputs 0, and the next byte is received correctly.
- With AUD_PARITY_EN, send 0x01 with parity bit 0 -> rx_err pulses and the byte is discarded. Parity bit 1 -> byte accepted.
